// File: rtl/spi_pkg.sv
// Shared types and config_data field positions for the SPI master core and its sck generator.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_END
    } state_e;

    // Registered leading/trailing/last_edge strobes are high in the cycle after sck moves.
    typedef struct packed {
        logic half_tick;
        logic xfer_end;
        logic leading;
        logic trailing;
        logic last_edge;
    } edge_t;

    function automatic int cpol_bit(input int width_log);
        return width_log + 1;
    endfunction

    function automatic int cpha_bit(input int width_log);
        return width_log;
    endfunction

    function automatic int width_lsb(input int width_log);
        return (width_log > 0) ? 0 : 0;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period divider and sck toggle register; one transfer spans 2N+2 half-periods
// (setup, 2N edges, hold), all of clk_div+1 cycles.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int SPI_MAX_WIDTH_LOG = 4,
    parameter int CLK_DIV_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         cpol,
    input  logic [CLK_DIV_WIDTH-1:0]     clk_div,
    input  logic [SPI_MAX_WIDTH_LOG-1:0] bit_count,
    output logic                         sck,
    output edge_t                        edges
);

    localparam int HPW = SPI_MAX_WIDTH_LOG + 2;

    logic [CLK_DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [HPW-1:0]           hp_cnt_q, hp_cnt_d;
    logic [HPW-1:0]           two_n;
    logic                     tog_q, tog_d;
    logic                     lead_q, lead_d;
    logic                     trail_q, trail_d;
    logic                     last_q, last_d;
    logic                     tick;
    logic                     edge_now;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_cnt_d = div_cnt_q;
        hp_cnt_d  = hp_cnt_q;
        tog_d     = tog_q;
        two_n     = ({2'b00, bit_count} + HPW'(1)) << 1;
        tick      = enable && (div_cnt_q == clk_div);
        edge_now  = tick && (hp_cnt_q < two_n);

        if (!enable) begin
            div_cnt_d = '0;
            hp_cnt_d  = '0;
            tog_d     = 1'b0;
        end else if (tick) begin
            div_cnt_d = '0;
            hp_cnt_d  = hp_cnt_q + HPW'(1);
        end else begin
            div_cnt_d = div_cnt_q + CLK_DIV_WIDTH'(1);
        end

        if (edge_now) begin
            tog_d = ~tog_q;
        end

        lead_d  = edge_now && !hp_cnt_q[0];
        trail_d = edge_now && hp_cnt_q[0];
        last_d  = edge_now && (hp_cnt_q == two_n - HPW'(1));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            hp_cnt_q  <= '0;
            tog_q     <= 1'b0;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hp_cnt_q  <= hp_cnt_d;
            tog_q     <= tog_d;
            lead_q    <= lead_d;
            trail_q   <= trail_d;
            last_q    <= last_d;
        end
    end

    assign sck             = cpol ^ tog_q;
    assign edges.half_tick = tick;
    assign edges.xfer_end  = tick && (hp_cnt_q == two_n);
    assign edges.leading   = lead_q;
    assign edges.trailing  = trail_q;
    assign edges.last_edge = last_q;

endmodule

// File: rtl/spi_master_core.sv
// SPI master engine: FSM, config, shift registers and miso synchroniser.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that samples internal mosi instead of miso.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int SPI_MAX_WIDTH_LOG = 4,
    parameter int CLK_DIV_WIDTH     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            config_req,
    input  logic [SPI_MAX_WIDTH_LOG+1:0]    config_data,
    input  logic [CLK_DIV_WIDTH-1:0]        clk_div,
    input  logic                            start,
    input  logic [2**SPI_MAX_WIDTH_LOG-1:0] din,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                            loopback,
`endif
    output logic                            busy,
    output logic                            done,
    output logic [2**SPI_MAX_WIDTH_LOG-1:0] dout,
    output logic                            sck,
    output logic                            cs,
    output logic                            mosi,
    input  logic                            miso
);

    localparam int W         = 2 ** SPI_MAX_WIDTH_LOG;
    localparam int CPOL_BIT  = cpol_bit(SPI_MAX_WIDTH_LOG);
    localparam int CPHA_BIT  = cpha_bit(SPI_MAX_WIDTH_LOG);
    localparam int WIDTH_LSB = width_lsb(SPI_MAX_WIDTH_LOG);

    state_e                       state_q, state_d;
    logic                         cpol_q, cpol_d;
    logic                         cpha_q, cpha_d;
    logic [SPI_MAX_WIDTH_LOG-1:0] width_q, width_d;
    logic [CLK_DIV_WIDTH-1:0]     div_q, div_d;
    logic [W-1:0]                 tx_q, tx_d;
    logic [W-1:0]                 rx_q, rx_d;
    logic [W-1:0]                 dout_q, dout_d;
    logic                         mosi_q, mosi_d;
    logic                         miso_s1_q, miso_s1_d;
    logic                         miso_s2_q, miso_s2_d;
    logic [W-1:0]                 aligned;
    logic                         active;
    logic                         sample_bit;
    logic                         shift_ev;
    logic                         sample_ev;
    edge_t                        edges;

    assign active = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = loopback ? mosi_q : miso_s2_q;
`else
    assign sample_bit = miso_s2_q;
`endif

    spi_sck_gen #(
        .SPI_MAX_WIDTH_LOG(SPI_MAX_WIDTH_LOG),
        .CLK_DIV_WIDTH    (CLK_DIV_WIDTH)
    ) u_sck_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (active),
        .cpol     (cpol_q),
        .clk_div  (div_q),
        .bit_count(width_q),
        .sck      (sck),
        .edges    (edges)
    );

    always_comb begin
        state_d   = state_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        width_d   = width_q;
        div_d     = div_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        mosi_d    = mosi_q;
        dout_d    = dout_q;
        miso_s1_d = miso;
        miso_s2_d = miso_s1_q;
        // Left-justify the word so the first bit to send always sits at the top of tx.
        aligned   = din << (~width_q);
        shift_ev  = cpha_q ? edges.leading : (edges.trailing && !edges.last_edge);
        sample_ev = cpha_q ? edges.trailing : edges.leading;

        if (shift_ev) begin
            mosi_d = tx_q[W-1];
            tx_d   = tx_q << 1;
        end
        if (sample_ev) begin
            rx_d = {rx_q[W-2:0], sample_bit};
        end

        case (state_q)
            ST_IDLE: begin
                mosi_d = 1'b0;
                if (config_req) begin
                    cpol_d  = config_data[CPOL_BIT];
                    cpha_d  = config_data[CPHA_BIT];
                    width_d = config_data[WIDTH_LSB +: SPI_MAX_WIDTH_LOG];
                end else if (start) begin
                    state_d = ST_SETUP;
                    div_d   = clk_div;
                    rx_d    = '0;
                    if (cpha_q) begin
                        tx_d = aligned;
                    end else begin
                        mosi_d = aligned[W-1];
                        tx_d   = aligned << 1;
                    end
                end
            end
            ST_SETUP: if (edges.half_tick) state_d = ST_XFER;
            ST_XFER:  if (edges.xfer_end) state_d = ST_HOLD;
            ST_HOLD: begin
                if (edges.half_tick) begin
                    state_d = ST_END;
                    dout_d  = rx_q;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                mosi_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            width_q   <= '1;
            div_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            dout_q    <= '0;
            mosi_q    <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            width_q   <= width_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            dout_q    <= dout_d;
            mosi_q    <= mosi_d;
            miso_s1_q <= miso_s1_d;
            miso_s2_q <= miso_s2_d;
        end
    end

    assign busy = active;
    assign cs   = ~active;
    assign done = (state_q == ST_END);
    assign dout = dout_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core with a behavioural SPI slave on the pins.
// Define SPI_MASTER_LOOPBACK_EN to also exercise the loopback input.
module tb_spi_master_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        config_req;
    logic [5:0]  config_data;
    logic [7:0]  clk_div;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic        sck;
    logic        cs;
    logic        mosi;
    logic        miso;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic        loopback;
`endif

    int checks = 0;
    int errors = 0;

    // Bench copy of the configuration the DUT should hold.
    logic        tb_cpol = 1'b0;
    logic        tb_cpha = 1'b0;
    int          tb_width = 15;

    // Slave model state.
    logic [15:0] slave_word = '0;
    logic [15:0] cap = '0;
    int          lead_cnt = 0;
    int          s_idx = 0;
    logic        cs_prev = 1'b1;
    logic        sck_prev = 1'b0;

    spi_master_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .config_req (config_req),
        .config_data(config_data),
        .clk_div    (clk_div),
        .start      (start),
        .din        (din),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .sck        (sck),
        .cs         (cs),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Slave: captures mosi on its sampling edge, drives miso MSB first.
    always @(sck or cs) begin
        if (cs_prev && !cs) begin
            cap      = '0;
            lead_cnt = 0;
            if (!tb_cpha) begin
                miso  = slave_word[tb_width];
                s_idx = tb_width - 1;
            end else begin
                s_idx = tb_width;
            end
        end else if (cs === 1'b0 && sck !== sck_prev) begin
            if (sck !== tb_cpol) begin
                lead_cnt++;
                if (tb_cpha) begin
                    if (s_idx >= 0) miso = slave_word[s_idx];
                    s_idx--;
                end else begin
                    cap = {cap[14:0], mosi};
                end
            end else begin
                if (tb_cpha) begin
                    cap = {cap[14:0], mosi};
                end else begin
                    if (s_idx >= 0) miso = slave_word[s_idx];
                    s_idx--;
                end
            end
        end
        cs_prev  = cs;
        sck_prev = sck;
    end

    task automatic set_cfg(input logic c, input logic p, input int w);
        @(negedge clk);
        config_req  = 1'b1;
        config_data = {c, p, 4'(w)};
        @(negedge clk);
        config_req  = 1'b0;
        tb_cpol     = c;
        tb_cpha     = p;
        tb_width    = w;
    endtask

    // One transfer; optionally pulses start+config_req mid-transfer.
    task automatic do_xfer(input logic [15:0] d, input logic [15:0] sw, input logic [7:0] div,
                           input logic inj, input logic [5:0] inj_cfg,
                           output int cs_cnt, output int done_cnt, output logic [15:0] cap_o,
                           output int lead_o, output bit to);
        int post;
        bit seen;
        slave_word = sw;
        din        = d;
        clk_div    = div;
        if (!tb_cpha) miso = sw[tb_width];
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cs_cnt   = 0;
        done_cnt = 0;
        post     = 0;
        seen     = 1'b0;
        to       = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!cs) cs_cnt++;
            if (done) begin
                done_cnt++;
                seen = 1'b1;
            end
            if (inj && i == 10) begin
                start       = 1'b1;
                config_req  = 1'b1;
                config_data = inj_cfg;
            end else begin
                start      = 1'b0;
                config_req = 1'b0;
            end
            if (seen) post++;
            if (post > 4) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        cap_o  = cap;
        lead_o = lead_cnt;
    endtask

    task automatic check_xfer(input string name, input int cs_cnt, input int done_cnt,
                              input logic [15:0] cap_o, input int lead_o, input bit to,
                              input int exp_cs, input logic [15:0] exp_dout,
                              input logic [15:0] exp_cap, input int exp_lead);
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout: done never seen", name); end
        checks++;
        if (cs_cnt !== exp_cs) begin errors++; $display("FAIL %s_cs_low: got %0d, required %0d", name, cs_cnt, exp_cs); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt); end
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL %s_dout: got %h, required %h", name, dout, exp_dout); end
        checks++;
        if (cap_o !== exp_cap) begin errors++; $display("FAIL %s_mosi: got %h, required %h", name, cap_o, exp_cap); end
        checks++;
        if (lead_o !== exp_lead) begin errors++; $display("FAIL %s_sck_edges: got %0d, required %0d", name, lead_o, exp_lead); end
        checks++;
        if (mosi !== 1'b0 || busy !== 1'b0 || cs !== 1'b1) begin
            errors++; $display("FAIL %s_idle_pins: got mosi=%b busy=%b cs=%b, required 0 0 1", name, mosi, busy, cs);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; config_req = 1'b0; config_data = '0; clk_div = '0;
        start = 1'b0; din = '0; miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({sck, cs, mosi, busy, done} !== 5'b01000) begin
            errors++; $display("FAIL reset_pins: got sck,cs,mosi,busy,done=%b, required 01000", {sck, cs, mosi, busy, done});
        end
        checks++;
        if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h, required 0000", dout); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cs !== 1'b1 || sck !== 1'b0) begin errors++; $display("FAIL reset_release: got cs=%b sck=%b, required 1 0", cs, sck); end
    endtask

    task automatic test_mode0;
        int c, dn, l; logic [15:0] cp; bit to;
        set_cfg(1'b0, 1'b0, 7);
        do_xfer(16'h00A5, 16'h003C, 8'd1, 1'b0, 6'd0, c, dn, cp, l, to);
        check_xfer("mode0", c, dn, cp, l, to, 36, 16'h003C, 16'h00A5, 8);
    endtask

    task automatic test_mode3;
        int c, dn, l; logic [15:0] cp; bit to;
        set_cfg(1'b1, 1'b1, 15);
        checks++;
        if (sck !== 1'b1) begin errors++; $display("FAIL mode3_idle_sck: got %b, required 1", sck); end
        do_xfer(16'hBEEF, 16'h1234, 8'd3, 1'b0, 6'd0, c, dn, cp, l, to);
        check_xfer("mode3", c, dn, cp, l, to, 136, 16'h1234, 16'hBEEF, 16);
        checks++;
        if (sck !== 1'b1) begin errors++; $display("FAIL mode3_end_sck: got %b, required 1", sck); end
    endtask

    task automatic test_width1;
        int c, dn, l; logic [15:0] cp; bit to;
        set_cfg(1'b0, 1'b0, 0);
        do_xfer(16'h0001, 16'h0001, 8'd0, 1'b0, 6'd0, c, dn, cp, l, to);
        check_xfer("width1", c, dn, cp, l, to, 4, 16'h0001, 16'h0001, 1);
    endtask

    task automatic test_back_to_back;
        bit seen;
        int dn;
        slave_word = 16'h0000;
        miso = 1'b0;
        din = 16'h0000;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done) seen = 1'b1; else @(negedge clk);
        end
        checks++;
        if (!seen || dout !== 16'h0000) begin errors++; $display("FAIL b2b_first: got seen=%b dout=%h, required 1 0000", seen, dout); end
        slave_word = 16'h0001;
        miso = 1'b1;
        din = 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cs !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got cs=%b busy=%b, required 0 1", cs, busy); end
        seen = 1'b0;
        dn = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin dn++; seen = 1'b1; end
            @(negedge clk);
        end
        checks++;
        if (dn !== 1 || dout !== 16'h0001) begin errors++; $display("FAIL b2b_second: got done=%0d dout=%h, required 1 0001", dn, dout); end
    endtask

    task automatic test_busy_ignore;
        int c, dn, l; logic [15:0] cp; bit to;
        bit went_low;
        set_cfg(1'b0, 1'b0, 7);
        do_xfer(16'h005A, 16'h00C3, 8'd1, 1'b1, {1'b1, 1'b0, 4'd3}, c, dn, cp, l, to);
        check_xfer("busy_ignore", c, dn, cp, l, to, 36, 16'h00C3, 16'h005A, 8);
        checks++;
        if (sck !== 1'b0) begin errors++; $display("FAIL busy_cfg_sck: got %b, required 0", sck); end
        @(negedge clk);
        config_req  = 1'b1;
        start       = 1'b1;
        config_data = {1'b1, 1'b1, 4'd3};
        @(negedge clk);
        config_req = 1'b0;
        start      = 1'b0;
        tb_cpol = 1'b1; tb_cpha = 1'b1; tb_width = 3;
        checks++;
        if (sck !== 1'b1) begin errors++; $display("FAIL cfg_start_sck: got %b, required 1", sck); end
        went_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cs !== 1'b1 || done !== 1'b0) went_low = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (went_low) begin errors++; $display("FAIL cfg_start_dropped: got a transfer, required none"); end
    endtask

    task automatic test_reset_mid;
        int c, dn, l; logic [15:0] cp; bit to;
        slave_word = 16'h0005;
        din = 16'h000F;
        clk_div = 8'd3;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        checks++;
        if (cs !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got cs=%b, required 0", cs); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs, sck, busy, done} !== 4'b1000 || dout !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_abort: got cs,sck,busy,done=%b dout=%h, required 1000 0000", {cs, sck, busy, done}, dout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tb_cpol = 1'b0; tb_cpha = 1'b0; tb_width = 15;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d, required 0", dn); end
        do_xfer(16'h1357, 16'hC3A5, 8'd1, 1'b0, 6'd0, c, dn, cp, l, to);
        check_xfer("after_reset", c, dn, cp, l, to, 68, 16'hC3A5, 16'h1357, 16);
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback;
        int c, dn, l; logic [15:0] cp; bit to;
        set_cfg(1'b0, 1'b0, 11);
        loopback = 1'b1;
        do_xfer(16'h0ABC, 16'h0000, 8'd1, 1'b0, 6'd0, c, dn, cp, l, to);
        check_xfer("loopback", c, dn, cp, l, to, 52, 16'h0ABC, 16'h0ABC, 12);
        loopback = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_width1;
        test_back_to_back;
        test_busy_ignore;
        test_reset_mid;
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
